// File: rtl/ex_wb_collect_pkg.sv
// rtl/ex_wb_collect_pkg.sv - shared constants, types and pointer helper for the EX->WB result collector
package ex_wb_collect_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int IDX_W_DEF  = 6;
   localparam int NUM_UNITS  = 4;
   localparam int NUM_WB     = 2;

   typedef enum logic [1:0] {
      ALU1 = 2'd0,
      ALU2 = 2'd1,
      MULT = 2'd2,
      LD   = 2'd3
   } unit_e;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [IDX_W_DEF-1:0]  phy_addr;
      logic                  reg_wrt;
      logic [IDX_W_DEF-1:0]  done_idx;
   } wb_entry_t;

   // Circular-buffer index advance for depths that are not a power of two.
   function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                            input int unsigned depth);
      return (base + off >= depth) ? base + off - depth : base + off;
   endfunction
endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - 4-write/2-read age-ordered result buffer with packed enqueue
// Accepts as many arrivals as free slots (including slots freed by this cycle's drain).
module wb_result_fifo
   import ex_wb_collect_pkg::*;
#(
   parameter int DEPTH = 12,
   parameter int ENT_W = 29
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic [NUM_UNITS-1:0]              wr_vld,
   input  logic [NUM_UNITS-1:0][ENT_W-1:0]   wr_ent,
   output logic [NUM_WB-1:0]                 rd_vld,
   output logic [NUM_WB-1:0][ENT_W-1:0]      rd_ent,
   output logic [$clog2(DEPTH+1)-1:0]        count_next,
   output logic                              drop
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      int unsigned n_drain;
      int unsigned space;
      int unsigned slot;
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      drop   = 1'b0;

      rd_vld[0] = (count_q != '0);
      rd_vld[1] = (count_q > CNT_W'(1));
      rd_ent[0] = rd_vld[0] ? mem_q[head_q] : '0;
      rd_ent[1] = rd_vld[1] ? mem_q[PTR_W'(wrap_add(32'(head_q), 1, DEPTH))] : '0;

      n_drain = 32'(rd_vld[0]) + 32'(rd_vld[1]);
      space   = DEPTH - 32'(count_q) + n_drain;
      slot    = 0;

      // Unit index order is the packing priority; once space runs out every later unit is dropped.
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (wr_vld[u] && !flush) begin
            if (slot < space) begin
               mem_d[PTR_W'(wrap_add(32'(tail_q), slot, DEPTH))] = wr_ent[u];
               slot = slot + 1;
            end else begin
               drop = 1'b1;
            end
         end
      end

      tail_d  = PTR_W'(wrap_add(32'(tail_q), slot, DEPTH));
      head_d  = PTR_W'(wrap_add(32'(head_q), n_drain, DEPTH));
      count_d = CNT_W'(32'(count_q) + slot - n_drain);
      if (flush) begin
         head_d  = tail_q;
         tail_d  = tail_q;
         count_d = '0;
      end
      count_next = count_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/ex_wb_collect.sv
// rtl/ex_wb_collect.sv - EX->WB result collector: buffers up to 4 results/cycle, drains 2 to RF/ROB
// Optional WB_FLUSH_EN adds flush_in, which empties the buffer and drops that cycle's arrivals.
module ex_wb_collect
   import ex_wb_collect_pkg::*;
#(
   parameter int DEPTH  = 12,
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef WB_FLUSH_EN
   input  logic              flush_in,
`endif
   input  logic              alu1_vld_ex_wb_in,
   input  logic [DATA_W-1:0] alu1_data_ex_wb_in,
   input  logic [IDX_W-1:0]  alu1_phy_addr_ex_wb_in,
   input  logic              alu1_reg_wrt_ex_wb_in,
   input  logic [IDX_W-1:0]  alu1_done_idx_ex_wb_in,
   input  logic              alu2_vld_ex_wb_in,
   input  logic [DATA_W-1:0] alu2_data_ex_wb_in,
   input  logic [IDX_W-1:0]  alu2_phy_addr_ex_wb_in,
   input  logic              alu2_reg_wrt_ex_wb_in,
   input  logic [IDX_W-1:0]  alu2_done_idx_ex_wb_in,
   input  logic              mult_vld_ex_wb_in,
   input  logic [DATA_W-1:0] mult_data_ex_wb_in,
   input  logic [IDX_W-1:0]  mult_phy_addr_ex_wb_in,
   input  logic              mult_reg_wrt_ex_wb_in,
   input  logic [IDX_W-1:0]  mult_done_idx_ex_wb_in,
   input  logic              ld_vld_ex_wb_in,
   input  logic [DATA_W-1:0] ld_data_ex_wb_in,
   input  logic [IDX_W-1:0]  ld_phy_addr_ex_wb_in,
   input  logic              ld_reg_wrt_ex_wb_in,
   input  logic [IDX_W-1:0]  ld_done_idx_ex_wb_in,
   output logic              wrt0_en_out,
   output logic [IDX_W-1:0]  wrt0_addr_out,
   output logic [DATA_W-1:0] wrt0_data_out,
   output logic              wrt1_en_out,
   output logic [IDX_W-1:0]  wrt1_addr_out,
   output logic [DATA_W-1:0] wrt1_data_out,
   output logic              done0_vld_out,
   output logic [IDX_W-1:0]  done0_idx_out,
   output logic              done1_vld_out,
   output logic [IDX_W-1:0]  done1_idx_out,
   output logic              stall_out,
   output logic              ovf_err_out
);
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [IDX_W-1:0]  phy_addr;
      logic              reg_wrt;
      logic [IDX_W-1:0]  done_idx;
   } ent_t;

   localparam int ENT_W = $bits(ent_t);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [NUM_UNITS-1:0] wr_vld;
   ent_t [NUM_UNITS-1:0] wr_ent;
   logic [NUM_WB-1:0]    rd_vld;
   ent_t [NUM_WB-1:0]    rd_ent;
   logic [CNT_W-1:0]     count_next;
   logic                 drop;
   logic                 flush;
   logic                 stall_q, stall_d;
   logic                 ovf_q, ovf_d;

`ifdef WB_FLUSH_EN
   assign flush = flush_in;
`else
   assign flush = 1'b0;
`endif

   always_comb begin
      wr_vld       = '0;
      wr_ent       = '0;
      wr_vld[ALU1] = alu1_vld_ex_wb_in;
      wr_vld[ALU2] = alu2_vld_ex_wb_in;
      wr_vld[MULT] = mult_vld_ex_wb_in;
      wr_vld[LD]   = ld_vld_ex_wb_in;
      wr_ent[ALU1] = '{alu1_data_ex_wb_in, alu1_phy_addr_ex_wb_in, alu1_reg_wrt_ex_wb_in,
                       alu1_done_idx_ex_wb_in};
      wr_ent[ALU2] = '{alu2_data_ex_wb_in, alu2_phy_addr_ex_wb_in, alu2_reg_wrt_ex_wb_in,
                       alu2_done_idx_ex_wb_in};
      wr_ent[MULT] = '{mult_data_ex_wb_in, mult_phy_addr_ex_wb_in, mult_reg_wrt_ex_wb_in,
                       mult_done_idx_ex_wb_in};
      wr_ent[LD]   = '{ld_data_ex_wb_in, ld_phy_addr_ex_wb_in, ld_reg_wrt_ex_wb_in,
                       ld_done_idx_ex_wb_in};
   end

   wb_result_fifo #(
      .DEPTH (DEPTH),
      .ENT_W (ENT_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .wr_vld     (wr_vld),
      .wr_ent     (wr_ent),
      .rd_vld     (rd_vld),
      .rd_ent     (rd_ent),
      .count_next (count_next),
      .drop       (drop)
   );

   // Invalid read entries come back zeroed, so only the write-enable gating is needed here.
   always_comb begin
      done0_vld_out = rd_vld[0];
      done0_idx_out = rd_ent[0].done_idx;
      done1_vld_out = rd_vld[1];
      done1_idx_out = rd_ent[1].done_idx;
      wrt0_en_out   = rd_vld[0] & rd_ent[0].reg_wrt;
      wrt1_en_out   = rd_vld[1] & rd_ent[1].reg_wrt;
      wrt0_addr_out = (rd_vld[0] & rd_ent[0].reg_wrt) ? rd_ent[0].phy_addr : '0;
      wrt0_data_out = (rd_vld[0] & rd_ent[0].reg_wrt) ? rd_ent[0].data : '0;
      wrt1_addr_out = (rd_vld[1] & rd_ent[1].reg_wrt) ? rd_ent[1].phy_addr : '0;
      wrt1_data_out = (rd_vld[1] & rd_ent[1].reg_wrt) ? rd_ent[1].data : '0;
   end

   always_comb begin
      stall_d = !flush && (count_next > CNT_W'(DEPTH - 8));
      ovf_d   = ovf_q | drop;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         stall_q <= stall_d;
         ovf_q   <= ovf_d;
      end
   end

   assign stall_out   = stall_q;
   assign ovf_err_out = ovf_q;
endmodule

// File: tb/tb_ex_wb_collect.sv
// tb/tb_ex_wb_collect.sv - table-driven bench for ex_wb_collect (DEPTH=12), optional WB_FLUSH_EN section
module tb_ex_wb_collect;
   import ex_wb_collect_pkg::*;

   localparam int DW = DATA_W_DEF;
   localparam int IW = IDX_W_DEF;

   typedef struct {
      logic [3:0]      vld;
      wb_entry_t [3:0] ent;
      logic            v0;
      wb_entry_t       e0;
      logic            v1;
      wb_entry_t       e1;
      logic            stall;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [3:0]      vld;
   wb_entry_t [3:0] ent;
`ifdef WB_FLUSH_EN
   logic            flush_in = 1'b0;
`endif
   logic            wrt0_en_out, wrt1_en_out, done0_vld_out, done1_vld_out;
   logic [IW-1:0]   wrt0_addr_out, wrt1_addr_out, done0_idx_out, done1_idx_out;
   logic [DW-1:0]   wrt0_data_out, wrt1_data_out;
   logic            stall_out, ovf_err_out;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];
   vec_t vt[$];

   ex_wb_collect dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
`ifdef WB_FLUSH_EN
      .flush_in               (flush_in),
`endif
      .alu1_vld_ex_wb_in      (vld[0]),
      .alu1_data_ex_wb_in     (ent[0].data),
      .alu1_phy_addr_ex_wb_in (ent[0].phy_addr),
      .alu1_reg_wrt_ex_wb_in  (ent[0].reg_wrt),
      .alu1_done_idx_ex_wb_in (ent[0].done_idx),
      .alu2_vld_ex_wb_in      (vld[1]),
      .alu2_data_ex_wb_in     (ent[1].data),
      .alu2_phy_addr_ex_wb_in (ent[1].phy_addr),
      .alu2_reg_wrt_ex_wb_in  (ent[1].reg_wrt),
      .alu2_done_idx_ex_wb_in (ent[1].done_idx),
      .mult_vld_ex_wb_in      (vld[2]),
      .mult_data_ex_wb_in     (ent[2].data),
      .mult_phy_addr_ex_wb_in (ent[2].phy_addr),
      .mult_reg_wrt_ex_wb_in  (ent[2].reg_wrt),
      .mult_done_idx_ex_wb_in (ent[2].done_idx),
      .ld_vld_ex_wb_in        (vld[3]),
      .ld_data_ex_wb_in       (ent[3].data),
      .ld_phy_addr_ex_wb_in   (ent[3].phy_addr),
      .ld_reg_wrt_ex_wb_in    (ent[3].reg_wrt),
      .ld_done_idx_ex_wb_in   (ent[3].done_idx),
      .wrt0_en_out            (wrt0_en_out),
      .wrt0_addr_out          (wrt0_addr_out),
      .wrt0_data_out          (wrt0_data_out),
      .wrt1_en_out            (wrt1_en_out),
      .wrt1_addr_out          (wrt1_addr_out),
      .wrt1_data_out          (wrt1_data_out),
      .done0_vld_out          (done0_vld_out),
      .done0_idx_out          (done0_idx_out),
      .done1_vld_out          (done1_vld_out),
      .done1_idx_out          (done1_idx_out),
      .stall_out              (stall_out),
      .ovf_err_out            (ovf_err_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_ports(input string tag, input logic v0, input wb_entry_t e0,
                              input logic v1, input wb_entry_t e1);
      logic en0, en1;
      en0 = v0 & e0.reg_wrt;
      en1 = v1 & e1.reg_wrt;
      chk({tag, " done0_vld"}, 32'(done0_vld_out), 32'(v0));
      chk({tag, " done0_idx"}, 32'(done0_idx_out), v0 ? 32'(e0.done_idx) : 32'd0);
      chk({tag, " wrt0_en"},   32'(wrt0_en_out),   32'(en0));
      chk({tag, " wrt0_addr"}, 32'(wrt0_addr_out), en0 ? 32'(e0.phy_addr) : 32'd0);
      chk({tag, " wrt0_data"}, 32'(wrt0_data_out), en0 ? 32'(e0.data) : 32'd0);
      chk({tag, " done1_vld"}, 32'(done1_vld_out), 32'(v1));
      chk({tag, " done1_idx"}, 32'(done1_idx_out), v1 ? 32'(e1.done_idx) : 32'd0);
      chk({tag, " wrt1_en"},   32'(wrt1_en_out),   32'(en1));
      chk({tag, " wrt1_addr"}, 32'(wrt1_addr_out), en1 ? 32'(e1.phy_addr) : 32'd0);
      chk({tag, " wrt1_data"}, 32'(wrt1_data_out), en1 ? 32'(e1.data) : 32'd0);
   endtask

   task automatic pop_cmp(input string name, input logic [IW-1:0] idx);
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got report idx %0d, required no further report", name, idx);
      end else begin
         chk(name, 32'(idx), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic drain_check(input string tag);
      if (done0_vld_out) pop_cmp({tag, " p0_idx"}, done0_idx_out);
      if (done1_vld_out) pop_cmp({tag, " p1_idx"}, done1_idx_out);
   endtask

   function automatic wb_entry_t mk(input int uid);
      wb_entry_t e;
      e.data     = DW'(32'hA000 + uid * 3);
      e.phy_addr = IW'(uid + 1);
      e.reg_wrt  = 1'b1;
      e.done_idx = IW'(uid);
      return e;
   endfunction

   function automatic vec_t mkv(input logic [3:0] v, input wb_entry_t [3:0] en,
                                input logic v0, input wb_entry_t e0,
                                input logic v1, input wb_entry_t e1, input logic st);
      vec_t r;
      r.vld = v; r.ent = en; r.v0 = v0; r.e0 = e0; r.v1 = v1; r.e1 = e1; r.stall = st;
      return r;
   endfunction

   task automatic load_six(input int base);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         vld = 4'hF;
         for (int u = 0; u < 4; u++) ent[u] = mk(base + c * 4 + u);
         @(posedge clk);
         #1;
      end
      chk("load6 stall", 32'(stall_out), 32'd1);
      check_ports("load6", 1'b1, mk(base + 2), 1'b1, mk(base + 3));
   endtask

   initial begin
      wb_entry_t       ez;
      wb_entry_t [3:0] none_e, s1, s4, sg, sh;
      wb_entry_t [3:0] bb [3];

      ez = '0;
      none_e = '0;
      s1 = '0;
      s1[0] = '{16'h1234, 6'd5, 1'b1, 6'd9};
      s4[0] = '{16'h1111, 6'd1, 1'b1, 6'd10};
      s4[1] = '{16'h2222, 6'd2, 1'b1, 6'd11};
      s4[2] = '{16'h3333, 6'd3, 1'b1, 6'd12};
      s4[3] = '{16'h4444, 6'd4, 1'b0, 6'd13};
      sg = '0;
      sg[1] = '{16'hBEEF, 6'd7, 1'b0, 6'd20};
      sh[0] = '{16'hDEAD, 6'd61, 1'b1, 6'd62};
      sh[1] = '{16'h5A5A, 6'd33, 1'b1, 6'd40};
      sh[2] = '{16'hF00D, 6'd63, 1'b1, 6'd63};
      sh[3] = '{16'hC3C3, 6'd34, 1'b1, 6'd41};
      for (int k = 0; k < 3; k++)
         for (int u = 0; u < 4; u++) bb[k][u] = mk(40 + k * 4 + u);

      vt.push_back(mkv(4'b0000, none_e, 0, ez, 0, ez, 0));
      vt.push_back(mkv(4'b0001, s1, 1, s1[0], 0, ez, 0));
      vt.push_back(mkv(4'b0000, none_e, 0, ez, 0, ez, 0));
      vt.push_back(mkv(4'b1111, s4, 1, s4[0], 1, s4[1], 0));
      vt.push_back(mkv(4'b0000, none_e, 1, s4[2], 1, s4[3], 0));
      vt.push_back(mkv(4'b0000, none_e, 0, ez, 0, ez, 0));
      vt.push_back(mkv(4'b0010, sg, 1, sg[1], 0, ez, 0));
      vt.push_back(mkv(4'b0000, none_e, 0, ez, 0, ez, 0));
      vt.push_back(mkv(4'b1010, sh, 1, sh[1], 1, sh[3], 0));
      vt.push_back(mkv(4'b0000, none_e, 0, ez, 0, ez, 0));
      vt.push_back(mkv(4'b1111, bb[0], 1, bb[0][0], 1, bb[0][1], 0));
      vt.push_back(mkv(4'b1111, bb[1], 1, bb[0][2], 1, bb[0][3], 1));
      vt.push_back(mkv(4'b1111, bb[2], 1, bb[1][0], 1, bb[1][1], 1));
      vt.push_back(mkv(4'b0000, none_e, 1, bb[1][2], 1, bb[1][3], 1));
      vt.push_back(mkv(4'b0000, none_e, 1, bb[2][0], 1, bb[2][1], 0));
      vt.push_back(mkv(4'b0000, none_e, 1, bb[2][2], 1, bb[2][3], 0));
      vt.push_back(mkv(4'b0000, none_e, 0, ez, 0, ez, 0));

      rst_n = 1'b0;
      vld = '0;
      ent = '0;
      repeat (2) @(posedge clk);
      #1;
      check_ports("reset", 1'b0, ez, 1'b0, ez);
      chk("reset stall", 32'(stall_out), 32'd0);
      chk("reset ovf", 32'(ovf_err_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         vld = vt[i].vld;
         ent = vt[i].ent;
         @(posedge clk);
         #1;
         check_ports($sformatf("vec%0d", i), vt[i].v0, vt[i].e0, vt[i].v1, vt[i].e1);
         chk($sformatf("vec%0d stall", i), 32'(stall_out), 32'(vt[i].stall));
         chk($sformatf("vec%0d ovf", i), 32'(ovf_err_out), 32'd0);
      end

      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         vld = 4'b0001;
         ent = '0;
         ent[0] = mk(i);
         @(posedge clk);
         #1;
         check_ports($sformatf("wrap%0d", i), 1'b1, mk(i), 1'b0, ez);
      end
      @(negedge clk);
      vld = '0;
      @(posedge clk);
      #1;
      check_ports("wrap_end", 1'b0, ez, 1'b0, ez);

      exp_q.delete();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         vld = 4'hF;
         for (int u = 0; u < 4; u++) begin
            ent[u] = mk(c * 4 + u);
            if (c < 5 || u < 2) exp_q.push_back(c * 4 + u);
         end
         @(posedge clk);
         #1;
         chk($sformatf("ovf c%0d", c), 32'(ovf_err_out), (c == 5) ? 32'd1 : 32'd0);
         drain_check($sformatf("ovf c%0d", c));
      end
      @(negedge clk);
      vld = '0;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("ovf sticky %0d", k), 32'(ovf_err_out), 32'd1);
         drain_check($sformatf("ovf drain%0d", k));
      end
      chk("ovf missing reports", 32'(exp_q.size()), 32'd0);
      check_ports("ovf empty", 1'b0, ez, 1'b0, ez);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("ovf cleared", 32'(ovf_err_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      load_six(0);
      @(negedge clk);
      vld = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_ports("midrst", 1'b0, ez, 1'b0, ez);
      chk("midrst stall", 32'(stall_out), 32'd0);
      chk("midrst ovf", 32'(ovf_err_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_ports("midrst after", 1'b0, ez, 1'b0, ez);

`ifdef WB_FLUSH_EN
      load_six(20);
      @(negedge clk);
      flush_in = 1'b1;
      vld = 4'hF;
      for (int u = 0; u < 4; u++) ent[u] = mk(50 + u);
      #1;
      check_ports("flush cycle", 1'b1, mk(22), 1'b1, mk(23));
      @(posedge clk);
      #1;
      check_ports("flushed", 1'b0, ez, 1'b0, ez);
      chk("flush stall", 32'(stall_out), 32'd0);
      @(negedge clk);
      flush_in = 1'b0;
      vld = '0;
      @(posedge clk);
      #1;
      check_ports("flush after", 1'b0, ez, 1'b0, ez);
      chk("flush ovf", 32'(ovf_err_out), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
